// File: rtl/vend_request_encoder_pkg.sv
// Shared encodings for the vending request front end: coin codes,
// selection codes, FSM states and debounce lane indices.
package vend_request_encoder_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_CANDY = 2'd1,
    SEL_SODA  = 2'd2
  } sel_t;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Debounced input lanes, in the order they are packed at the top level.
  localparam int NUM_LANES = 5;
  localparam int LN_COIN    = 0;
  localparam int LN_CANDY   = 1;
  localparam int LN_SODA    = 2;
  localparam int LN_CONFIRM = 3;
  localparam int LN_CANCEL  = 4;

  // Request as presented to the FSM.
  typedef struct packed {
    logic [1:0] coins;
    logic       ca;
    logic       sa;
  } req_t;

  function automatic req_t make_req(input logic [1:0] coins, input sel_t sel);
    req_t r;
    r.coins = coins;
    r.ca    = (sel == SEL_CANDY);
    r.sa    = (sel == SEL_SODA);
    return r;
  endfunction

endpackage

// File: rtl/vend_request_encoder_if.sv
// User-side raw inputs, FSM feedback and the request outputs towards the FSM.
interface vend_request_encoder_if;
  logic       coin_raw;
  logic       btn_candy_raw;
  logic       btn_soda_raw;
  logic       btn_confirm_raw;
  logic       btn_cancel_raw;
  logic       C_D;
  logic       S_D;
  logic [1:0] Coin_insert;
  logic       C_A;
  logic       S_A;
  logic       BTN_sensor;
  logic       coin_reject;
  logic       busy;

  // Drives the raw inputs and dispense feedback; observes the request.
  modport master (
    output coin_raw, btn_candy_raw, btn_soda_raw, btn_confirm_raw, btn_cancel_raw,
    output C_D, S_D,
    input  Coin_insert, C_A, S_A, BTN_sensor, coin_reject, busy
  );

  // The encoder itself.
  modport slave (
    input  coin_raw, btn_candy_raw, btn_soda_raw, btn_confirm_raw, btn_cancel_raw,
    input  C_D, S_D,
    output Coin_insert, C_A, S_A, BTN_sensor, coin_reject, busy
  );
endinterface

// File: rtl/vend_request_encoder_debounce.sv
// One debounce lane: 2-flop synchroniser, stability counter, and a
// single-cycle pulse on each accepted rising level.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_clean, r_rise;
  logic [CW-1:0] r_cnt;

  // Synchronise, then accept a new level only after it differs from the
  // clean level for DEBOUNCE_CYCLES consecutive samples; any return to the
  // clean level restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_s2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_clean <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;
endmodule

// File: rtl/vend_request_encoder.sv
// Vending request encoder: debounces the user inputs, collects coins and
// a selection, then holds one stable request for the slow FSM clock and
// waits for dispense feedback or a timeout.
module vend_request_encoder
  import vend_request_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int ACK_TIMEOUT     = 100_000_000
) (
  input  logic CLK,
  input  logic RST,
  vend_request_encoder_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  logic [NUM_LANES-1:0] w_raw, w_ev;

  assign w_raw[LN_COIN]    = bus.coin_raw;
  assign w_raw[LN_CANDY]   = bus.btn_candy_raw;
  assign w_raw[LN_SODA]    = bus.btn_soda_raw;
  assign w_raw[LN_CONFIRM] = bus.btn_confirm_raw;
  assign w_raw[LN_CANCEL]  = bus.btn_cancel_raw;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK    (CLK),
      .RST    (RST),
      .i_raw  (w_raw[g]),
      .o_rise (w_ev[g])
    );
  end

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_coins, w_coins_nxt;
  sel_t          r_sel,   w_sel_nxt;
  req_t          r_snap,  w_snap_nxt;
  logic [HW-1:0] r_hold,  w_hold_nxt;
  logic [TW-1:0] r_to,    w_to_nxt;
  logic          r_rej,   w_rej_nxt;
  req_t          w_out;

  // State, transaction registers and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= COLLECT;
      r_coins <= COIN_NONE;
      r_sel   <= SEL_NONE;
      r_snap  <= '0;
      r_hold  <= '0;
      r_to    <= '0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_coins <= w_coins_nxt;
      r_sel   <= w_sel_nxt;
      r_snap  <= w_snap_nxt;
      r_hold  <= w_hold_nxt;
      r_to    <= w_to_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  // Next-state and register updates for each phase of a transaction.
  always_comb begin
    w_state_nxt = r_state;
    w_coins_nxt = r_coins;
    w_sel_nxt   = r_sel;
    w_snap_nxt  = r_snap;
    w_hold_nxt  = r_hold;
    w_to_nxt    = r_to;
    w_rej_nxt   = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_ev[LN_CANCEL]) begin
          // Cancel overrides everything else arriving in the same cycle.
          w_coins_nxt = COIN_NONE;
          w_sel_nxt   = SEL_NONE;
        end else begin
          if (w_ev[LN_COIN]) begin
            if (r_coins == COIN_TWO) w_rej_nxt   = 1'b1;
            else                     w_coins_nxt = r_coins + 2'd1;
          end
          if (w_ev[LN_CANDY] && w_ev[LN_SODA]) w_sel_nxt = SEL_NONE;
          else if (w_ev[LN_CANDY])             w_sel_nxt = SEL_CANDY;
          else if (w_ev[LN_SODA])              w_sel_nxt = SEL_SODA;
          // An empty transaction is not worth sending; a selection with
          // no coins is, since the FSM reports that error itself.
          if (w_ev[LN_CONFIRM] && !(r_coins == COIN_NONE && r_sel == SEL_NONE)) begin
            w_snap_nxt  = make_req(r_coins, r_sel);
            w_hold_nxt  = '0;
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        w_rej_nxt = w_ev[LN_COIN];
        if (r_hold == HMAX) begin
          w_hold_nxt  = '0;
          w_to_nxt    = '0;
          w_state_nxt = WAIT_ACK;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      WAIT_ACK: begin
        w_rej_nxt = w_ev[LN_COIN];
        if (bus.C_D || bus.S_D || r_to == TMAX) begin
          w_coins_nxt = COIN_NONE;
          w_sel_nxt   = SEL_NONE;
          w_to_nxt    = '0;
          w_state_nxt = COLLECT;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Request outputs decoded from registers only, so reset clears them at once.
  always_comb begin
    w_out = '0;
    case (r_state)
      COLLECT: w_out = make_req(r_coins, r_sel);
      SEND:    w_out = r_snap;
      default: w_out = '0;
    endcase
  end

  assign bus.Coin_insert = w_out.coins;
  assign bus.C_A         = w_out.ca;
  assign bus.S_A         = w_out.sa;
  assign bus.BTN_sensor  = (r_state == SEND);
  assign bus.busy        = (r_state != COLLECT);
  assign bus.coin_reject = r_rej;
endmodule
